// File: rtl/iir_pkg.sv
// Shared definitions for the biquad cascade: sequencer states and coefficient tap order.
package iir_pkg;
   localparam int B0   = 0;
   localparam int B1   = 1;
   localparam int B2   = 2;
   localparam int A1   = 3;
   localparam int A2   = 4;
   localparam int TAPS = 5;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      OUT
   } state_e;
endpackage

// File: rtl/iir_mac.sv
// Shared multiply-accumulate: one signed product per cycle into a guard-bit accumulator,
// with the round-half-up / saturate view of the running sum available combinationally.
module iir_mac
   import iir_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en_i,
   input  logic                    first_i,
   input  logic                    sub_i,
   input  logic signed [WIDTH-1:0] coef_i,
   input  logic signed [WIDTH-1:0] data_i,
   output logic signed [WIDTH-1:0] res_o
);
   localparam int ACC_W = 2*WIDTH + 3;
   localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (FRAC-1);
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] r;
      r = (v + RND) >>> FRAC;
      if (r > MAXV)      round_sat = MAXV[WIDTH-1:0];
      else if (r < MINV) round_sat = MINV[WIDTH-1:0];
      else               round_sat = r[WIDTH-1:0];
   endfunction

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc_d;
   logic signed [ACC_W-1:0]   acc_q;

   // The first tap of a section restarts the sum instead of adding to the previous one.
   always_comb begin
      prod     = (2*WIDTH)'(coef_i) * (2*WIDTH)'(data_i);
      prod_ext = ACC_W'(prod);
      acc_d    = (first_i ? {ACC_W{1'b0}} : acc_q) + (sub_i ? -prod_ext : prod_ext);
      res_o    = round_sat(acc_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    acc_q <= '0;
      else if (en_i) acc_q <= acc_d;
   end
endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of direct-form-I biquads time-multiplexed onto one MAC, five taps per section.
module iir_biquad_cascade
   import iir_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int FRAC     = 14,
   parameter int N_STAGES = 3
) (
   input  logic                                  CLK,
   input  logic                                  rst_n,
   input  logic                                  clear,
   input  logic                                  bypass,
   input  logic                                  coeff_wr,
   input  logic [$clog2(TAPS*N_STAGES)-1:0]      coeff_addr,
   input  logic signed [WIDTH-1:0]               coeff_data,
   output logic                                  coeff_err,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic signed [WIDTH-1:0]               x_in,
   output logic                                  out_valid,
   output logic signed [WIDTH-1:0]               y_out
);
   localparam int NCOEF = TAPS * N_STAGES;
   localparam int AW    = $clog2(NCOEF);
   localparam int SW    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
   localparam logic signed [WIDTH-1:0] UNITY = WIDTH'(1) << FRAC;

   state_e            state_q, state_d;
   logic [2:0]        tap_q, tap_d;
   logic [SW-1:0]     stg_q, stg_d;

   logic signed [WIDTH-1:0] coef_q [NCOEF];
   logic signed [WIDTH-1:0] x1_q [N_STAGES];
   logic signed [WIDTH-1:0] x2_q [N_STAGES];
   logic signed [WIDTH-1:0] y1_q [N_STAGES];
   logic signed [WIDTH-1:0] y2_q [N_STAGES];
   logic signed [WIDTH-1:0] sec_q;
   logic signed [WIDTH-1:0] y_q;
   logic                    err_q;

   logic                    accept, wr_ok, sec_done, last_stg, mac_en;
   logic [AW-1:0]           cidx;
   logic signed [WIDTH-1:0] operand, mac_res;

   assign in_ready  = rst_n && (state_q == IDLE) && !clear;
   assign accept    = in_valid && in_ready;
   assign last_stg  = (stg_q == SW'(N_STAGES-1));
   assign mac_en    = (state_q == MAC) && !clear;
   assign sec_done  = mac_en && (tap_q == 3'(A2));
   assign wr_ok     = coeff_wr && (state_q == IDLE) && !accept && (int'(coeff_addr) < NCOEF);
   assign cidx      = AW'(int'(stg_q) * TAPS + int'(tap_q));
   assign out_valid = (state_q == OUT) && !clear;
   assign y_out     = y_q;
   assign coeff_err = err_q;

   always_comb begin
      operand = sec_q;
      case (tap_q)
         3'(B1):  operand = x1_q[stg_q];
         3'(B2):  operand = x2_q[stg_q];
         3'(A1):  operand = y1_q[stg_q];
         3'(A2):  operand = y2_q[stg_q];
         default: operand = sec_q;
      endcase
   end

   iir_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
      .clk     (CLK),
      .rst_n   (rst_n),
      .en_i    (mac_en),
      .first_i (tap_q == 3'(B0)),
      .sub_i   (tap_q >= 3'(A1)),
      .coef_i  (coef_q[cidx]),
      .data_i  (operand),
      .res_o   (mac_res)
   );

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      stg_d   = stg_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = bypass ? OUT : MAC;
            tap_d   = '0;
            stg_d   = '0;
         end
         MAC: if (tap_q == 3'(A2)) begin
            tap_d = '0;
            if (last_stg) state_d = OUT;
            else          stg_d   = stg_q + 1'b1;
         end else begin
            tap_d = tap_q + 3'd1;
         end
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Flush wins over everything, abandoning any sample in flight.
      if (clear) begin
         state_d = IDLE;
         tap_d   = '0;
         stg_d   = '0;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tap_q   <= '0;
         stg_q   <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         stg_q   <= stg_d;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCOEF; i++) coef_q[i] <= (i % TAPS == B0) ? UNITY : '0;
         for (int s = 0; s < N_STAGES; s++) begin
            x1_q[s] <= '0;
            x2_q[s] <= '0;
            y1_q[s] <= '0;
            y2_q[s] <= '0;
         end
         sec_q <= '0;
         y_q   <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= coeff_wr && !wr_ok;
         if (wr_ok) coef_q[coeff_addr] <= coeff_data;
         if (accept) begin
            sec_q <= x_in;
            if (bypass) y_q <= x_in;
         end
         if (clear) begin
            for (int s = 0; s < N_STAGES; s++) begin
               x1_q[s] <= '0;
               x2_q[s] <= '0;
               y1_q[s] <= '0;
               y2_q[s] <= '0;
            end
         end else if (sec_done) begin
            // Section result doubles as the next section's input.
            x2_q[stg_q] <= x1_q[stg_q];
            x1_q[stg_q] <= sec_q;
            y2_q[stg_q] <= y1_q[stg_q];
            y1_q[stg_q] <= mac_res;
            sec_q       <= mac_res;
            if (last_stg) y_q <= mac_res;
         end
      end
   end
endmodule

// File: doc/iir_biquad_cascade.md
IIR_BIQUAD_CASCADE -- requirements
Module: iir_biquad_cascade

Interface
REQ-001 Parameter WIDTH, 16, sample and coefficient width (signed two's complement).
REQ-002 Parameter FRAC, 14, coefficient fractional bits (Q(WIDTH-FRAC).FRAC).
REQ-003 Parameter N_STAGES, 3, number of cascaded biquad sections (range 1..8).
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 clear  input  1  synchronous flush of all section delay lines; coefficients kept.
REQ-007 bypass  input  1  when high, samples pass unfiltered.
REQ-008 coeff_wr  input  1  coefficient write strobe.
REQ-009 coeff_addr  input  clog2(5*N_STAGES)  index = stage*5 + {0:b0, 1:b1, 2:b2, 3:a1, 4:a2}.
REQ-010 coeff_data  input  WIDTH  coefficient value.
REQ-011 coeff_err  output  1  one-cycle pulse when a write is rejected.
REQ-012 in_valid / in_ready  input / output  1 each  sample handshake; accept when both high.
REQ-013 x_in  input  WIDTH  input sample.
REQ-014 out_valid  output  1  one-cycle pulse qualifying y_out.
REQ-015 y_out  output  WIDTH  filtered sample, held until next out_valid.

Function
REQ-016 Each section k SHALL compute y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2 (direct form I); section k input is section k-1 output; section 0 input is x_in.
REQ-017 One shared multiplier-accumulator SHALL perform all products, one product per cycle.
REQ-018 FSM states: IDLE (in_ready=1), MAC (5 cycles per section, tap counter 0..4, stage counter 0..N_STAGES-1), OUT (out_valid=1), then IDLE.
REQ-019 Accumulator width 2*WIDTH+3; no intermediate wrap.
REQ-020 Section result SHALL be acc + 2^(FRAC-1), arithmetic shift right by FRAC (round half up), saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-021 On section completion, that section's x2<=x1, x1<=section input, y2<=y1, y1<=saturated result.
REQ-022 Latency: out_valid SHALL assert exactly 5*N_STAGES+1 cycles after the accept edge; in_ready SHALL reassert the cycle after out_valid.
REQ-023 bypass sampled at accept: if high, y_out=x_in with out_valid 1 cycle after accept, delay lines unchanged.
REQ-024 Coefficient writes SHALL take effect only in IDLE with no simultaneous accept; otherwise ignored and coeff_err pulses next cycle.
REQ-025 coeff_addr >= 5*N_STAGES SHALL be ignored with coeff_err pulse.
REQ-026 clear SHALL zero all delay registers in one cycle; clear has priority over accept (in_ready low while clear high); clear in MAC/OUT aborts the sample, no out_valid, returns to IDLE.
REQ-027 in_valid while not in_ready SHALL be ignored (no buffering).

Reset
REQ-028 rst_n low SHALL force: FSM IDLE, counters 0, delay lines 0, accumulator 0, y_out 0, out_valid 0, coeff_err 0, in_ready 0 during reset and 1 the first cycle after release.
REQ-029 Reset coefficients: b0 = 2^FRAC (unity), b1=b2=a1=a2=0 for every section (pass-through).
REQ-030 Reset asserted mid-sample SHALL discard the sample with no out_valid.

Structure
REQ-031 Package iir_pkg SHALL hold the FSM state enum and tap index constants (B0..A2 = 0..4, TAPS=5).
REQ-032 Sub-module iir_mac SHALL contain multiply, accumulate, round and saturate; parameterised by WIDTH and FRAC.

Verification
REQ-033 Reset defaults, N_STAGES=3, x_in=1000 accepted -> out_valid at cycle 16, y_out=1000.
REQ-034 Section 0 b0=8192 (0.5): x=3 -> y=2; x=-3 -> y=-1 (round half up).
REQ-035 Section 0 b0=32767: x=30000 -> y=32767; x=-30000 -> y=-32768 (saturation).
REQ-036 Section 0 b0=0, b1=16384: impulse 1000 then zeros -> outputs 0, 1000, 0.
REQ-037 coeff_wr during MAC -> coeff_err pulse, coefficient unchanged; clear during MAC -> no out_valid, in_ready next cycle, next sample sees zeroed history.
REQ-038 bypass=1, x=-1234 -> y_out=-1234 one cycle after accept; subsequent filtered output matches history from before bypass.
